// File: rtl/mac_accumulator_pipe.sv
// Two-stage multiply-accumulate engine over CH channels: acc[ch] <= acc[ch] + m*x + c, with read/read-clear.
// Define FMA_ACC_SAT_EN to saturate on overflow and track the sticky per-channel overflow flag.
module mac_accumulator_pipe #(
  parameter int unsigned W     = 16,
  parameter int unsigned ACC_W = 40,
  parameter int unsigned CH    = 4,
  localparam int unsigned CW   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [CW-1:0]    in_ch,
  input  logic             in_sgn,
  input  logic [W-1:0]     in_m,
  input  logic [W-1:0]     in_x,
  input  logic [W-1:0]     in_c,
  input  logic [ACC_W-1:0] in_init,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_ch,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf
);

  localparam int unsigned P_W = 2 * W + 1;
  localparam logic [1:0] OP_MAC   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_RDCLR = 2'b11;
  localparam logic [CW:0] CH_LIM  = (CW + 1)'(CH);

  logic [P_W-1:0]   m_ext, x_ext, c_ext, p_raw;
  logic [ACC_W-1:0] p_ext;
  logic             ch_ok, adv, exec;

  logic             s1_valid;
  logic [1:0]       s1_op;
  logic [CW-1:0]    s1_ch;
  logic [ACC_W-1:0] s1_val;

  logic [ACC_W-1:0] acc [CH];
  logic             ovf [CH];
  logic [ACC_W-1:0] acc_cur, mac_res;
  logic             mac_ovf;

  // Product term at 2W+1 bits, extended to the accumulator width by operand signedness.
  always_comb begin
    m_ext = in_sgn ? {{(P_W - W){in_m[W-1]}}, in_m} : {{(P_W - W){1'b0}}, in_m};
    x_ext = in_sgn ? {{(P_W - W){in_x[W-1]}}, in_x} : {{(P_W - W){1'b0}}, in_x};
    c_ext = in_sgn ? {{(P_W - W){in_c[W-1]}}, in_c} : {{(P_W - W){1'b0}}, in_c};
    p_raw = P_W'(m_ext * x_ext) + c_ext;
    p_ext = in_sgn ? {{(ACC_W - P_W){p_raw[P_W-1]}}, p_raw}
                   : {{(ACC_W - P_W){1'b0}}, p_raw};
  end

  assign ch_ok    = ({1'b0, in_ch} < CH_LIM);
  assign adv      = !out_valid | out_ready;
  assign exec     = s1_valid & adv;
  assign in_ready = !s1_valid | adv;
  assign acc_cur  = acc[s1_ch];

`ifdef FMA_ACC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_SMAX = {1'b0, {(ACC_W - 1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_SMIN = {1'b1, {(ACC_W - 1){1'b0}}};
  logic             s1_sgn;
  logic [ACC_W:0]   sum_w;

  // Overflow detection and clamping toward the violated range limit.
  always_comb begin
    sum_w   = {1'b0, acc_cur} + {1'b0, s1_val};
    mac_ovf = 1'b0;
    mac_res = sum_w[ACC_W-1:0];
    if (s1_sgn) begin
      mac_ovf = (acc_cur[ACC_W-1] == s1_val[ACC_W-1]) && (sum_w[ACC_W-1] != acc_cur[ACC_W-1]);
      if (mac_ovf) mac_res = acc_cur[ACC_W-1] ? ACC_SMIN : ACC_SMAX;
    end else begin
      mac_ovf = sum_w[ACC_W];
      if (mac_ovf) mac_res = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) s1_sgn <= 1'b0;
    else if (in_ready) s1_sgn <= in_sgn;
  end
`else
  always_comb begin
    mac_ovf = 1'b0;
    mac_res = acc_cur + s1_val;
  end
`endif

  // S1 capture, S2 channel read-modify-write and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_op     <= OP_MAC;
      s1_ch     <= '0;
      s1_val    <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      for (int i = 0; i < int'(CH); i++) begin
        acc[i] <= '0;
        ovf[i] <= 1'b0;
      end
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid & ch_ok;
        s1_op    <= in_op;
        s1_ch    <= in_ch;
        s1_val   <= (in_op == OP_LOAD) ? in_init : p_ext;
      end
      if (adv) out_valid <= exec & s1_op[1];
      if (exec) begin
        case (s1_op)
          OP_MAC: begin
            acc[s1_ch] <= mac_res;
            ovf[s1_ch] <= ovf[s1_ch] | mac_ovf;
          end
          OP_LOAD: begin
            acc[s1_ch] <= s1_val;
            ovf[s1_ch] <= 1'b0;
          end
          OP_READ: begin
            out_ch   <= s1_ch;
            out_data <= acc_cur;
            out_ovf  <= ovf[s1_ch];
          end
          default: begin
            out_ch     <= s1_ch;
            out_data   <= acc_cur;
            out_ovf    <= ovf[s1_ch];
            acc[s1_ch] <= '0;
            ovf[s1_ch] <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mac_accumulator_pipe.sv
// Directed bench for mac_accumulator_pipe; expected values are hand-computed constants.
module tb_mac_accumulator_pipe;

  localparam logic [1:0] OP_MAC = 2'b00, OP_LOAD = 2'b01, OP_READ = 2'b10, OP_RDCLR = 2'b11;

`ifdef FMA_ACC_SAT_EN
  localparam logic [39:0] EXP_SOVF = 40'h7F_FFFF_FFFF;
  localparam logic [39:0] EXP_UOVF = 40'hFF_FFFF_FFFF;
  localparam logic        EXP_OVF  = 1'b1;
`else
  localparam logic [39:0] EXP_SOVF = 40'h80_0000_0000;
  localparam logic [39:0] EXP_UOVF = 40'h00_0000_0000;
  localparam logic        EXP_OVF  = 1'b0;
`endif

  logic        clk, rst, in_valid, in_ready, in_sgn, out_valid, out_ready, out_ovf;
  logic [1:0]  in_op, in_ch, out_ch;
  logic [15:0] in_m, in_x, in_c;
  logic [39:0] in_init, out_data;
  int ncmp = 0;
  int nerr = 0;
  int cyc;

  mac_accumulator_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_ch(in_ch), .in_sgn(in_sgn), .in_m(in_m), .in_x(in_x), .in_c(in_c),
    .in_init(in_init), .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a command at a falling edge and hold it until it is accepted.
  task automatic issue(input logic [1:0] op, input logic [1:0] ch, input logic sgn,
                       input logic [15:0] m, input logic [15:0] x, input logic [15:0] c,
                       input logic [39:0] init);
    int n;
    @(negedge clk);
    in_op = op; in_ch = ch; in_sgn = sgn; in_m = m; in_x = x; in_c = c; in_init = init;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("issue_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic mac(input logic [1:0] ch, input logic sgn, input logic [15:0] m,
                     input logic [15:0] x, input logic [15:0] c);
    issue(OP_MAC, ch, sgn, m, x, c, 40'd0);
  endtask

  task automatic load(input logic [1:0] ch, input logic [39:0] v);
    issue(OP_LOAD, ch, 1'b0, 16'd0, 16'd0, 16'd0, v);
  endtask

  task automatic rd(input logic [1:0] ch, input logic clr);
    issue(clr ? OP_RDCLR : OP_READ, ch, 1'b0, 16'd0, 16'd0, 16'd0, 40'd0);
  endtask

  task automatic check_out(input string tag, input logic [1:0] ch, input logic [39:0] d,
                           input logic ovf);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_ch"}, 64'(out_ch), 64'(ch));
    chk({tag, "_data"}, 64'(out_data), 64'(d));
    chk({tag, "_ovf"}, 64'(out_ovf), 64'(ovf));
  endtask

  task automatic wait_out(output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!out_valid && c < 50);
  endtask

  task automatic get(input string tag, input logic [1:0] ch, input logic [39:0] d,
                     input logic ovf);
    int c;
    wait_out(c);
    check_out(tag, ch, d, ovf);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_ch = 2'd0; in_sgn = 1'b0;
    in_m = '0; in_x = '0; in_c = '0; in_init = '0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_ch", 64'(out_ch), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_ovf", 64'(out_ovf), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;

    // 5 + 3*4 + 1 = 18, two-cycle read latency
    load(2'd0, 40'd5);
    mac(2'd0, 1'b0, 16'd3, 16'd4, 16'd1);
    rd(2'd0, 1'b0);
    wait_out(cyc);
    chk("read_latency", 64'(cyc), 64'd2);
    check_out("rd_ch0", 2'd0, 40'd18, 1'b0);

    // Signed: -1*2 + -1 = -3
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    mac(2'd1, 1'b1, 16'hFFFF, 16'h0002, 16'hFFFF);
    rd(2'd1, 1'b1);
    get("rdclr_ch1", 2'd1, 40'hFF_FFFF_FFFD, 1'b0);
    rd(2'd1, 1'b0);
    get("rd_ch1_cleared", 2'd1, 40'd0, 1'b0);

    // Four back-to-back unsigned MACs of 0xFFFF^2 then an immediate read
    for (int i = 0; i < 4; i++) mac(2'd2, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0000);
    rd(2'd2, 1'b0);
    get("rd_ch2_b2b", 2'd2, 40'h3_FFF8_0004, 1'b0);
    rd(2'd0, 1'b0);
    get("rd_ch0_untouched", 2'd0, 40'd0, 1'b0);
    rd(2'd1, 1'b0);
    get("rd_ch1_untouched", 2'd1, 40'd0, 1'b0);
    rd(2'd3, 1'b0);
    get("rd_ch3_untouched", 2'd3, 40'd0, 1'b0);

    // Backpressure: result stalled, S1 full, a third read waiting at the input
    load(2'd0, 40'h11);
    load(2'd1, 40'h22);
    load(2'd3, 40'h33);
    @(negedge clk); out_ready = 1'b0;
    rd(2'd0, 1'b0);
    rd(2'd1, 1'b0);
    @(negedge clk);
    in_op = OP_READ; in_ch = 2'd3; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      check_out("bp_hold", 2'd0, 40'h11, 1'b0);
    end
    out_ready = 1'b1;
    check_out("bp_r0", 2'd0, 40'h11, 1'b0);
    @(negedge clk);
    in_ch = 2'd2;
    check_out("bp_r1", 2'd1, 40'h22, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    check_out("bp_r2", 2'd3, 40'h33, 1'b0);
    @(negedge clk);
    check_out("bp_r3", 2'd2, 40'h3_FFF8_0004, 1'b0);
    @(negedge clk);
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Signed overflow at the positive limit, sticky flag, clear
    load(2'd3, 40'h7F_FFFF_FFFF);
    mac(2'd3, 1'b1, 16'd1, 16'd1, 16'd0);
    rd(2'd3, 1'b0);
    get("sovf", 2'd3, EXP_SOVF, EXP_OVF);
    rd(2'd3, 1'b1);
    get("sovf_sticky", 2'd3, EXP_SOVF, EXP_OVF);
    rd(2'd3, 1'b0);
    get("sovf_cleared", 2'd3, 40'd0, 1'b0);

    // Unsigned carry-out, then LOAD clears the flag
    load(2'd0, 40'hFF_FFFF_FFFF);
    mac(2'd0, 1'b0, 16'd1, 16'd1, 16'd0);
    rd(2'd0, 1'b0);
    get("uovf", 2'd0, EXP_UOVF, EXP_OVF);
    load(2'd0, 40'd5);
    rd(2'd0, 1'b0);
    get("load_clears_ovf", 2'd0, 40'd5, 1'b0);

    // Reset with a stalled result and a MAC in S1
    load(2'd2, 40'd7);
    @(negedge clk); out_ready = 1'b0;
    rd(2'd2, 1'b0);
    mac(2'd1, 1'b0, 16'd2, 16'd3, 16'd0);
    @(negedge clk);
    check_out("pre_rst_stall", 2'd2, 40'd7, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), 1'b0);
      get("post_rst_rd", 2'(i), 40'd0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion expected finish");
    $fatal(1, "watchdog");
  end

endmodule
